// File: rtl/tick_arbiter_pkg.sv
// Shared types and defaults for the tick arbiter and its tick generator.
package tick_arbiter_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tick_arbiter_tick_gen.sv
// Programmable divider: counts 0..div while enabled and emits a registered tick when the count reaches 1.
module tick_gen
    import tick_arbiter_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             r_tick;

    // next count value, wrapping to zero once the divider value is reached
    always_comb begin
        if (r_cnt == div) begin
            w_cnt_nxt = {DIV_W{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // counter and tick register; tick is aligned with the count value of 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= {DIV_W{1'b0}};
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= {DIV_W{1'b0}};
            r_tick <= 1'b0;
        end else if (en) begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == {{(DIV_W-1){1'b0}}, 1'b1});
        end else begin
            r_cnt  <= r_cnt;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/tick_arbiter.sv
// Round-robin owner of a shared tick generator. Optional per-grant tick budget
// with forced release is built when TICK_ARBITER_TIMEOUT_EN is defined.
module tick_arbiter
    import tick_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       rel,
    input  logic [NREQ*DIV_W-1:0] div_in,
    input  logic [7:0]            max_ticks,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  tick,
    output logic                  timeout
);

    localparam int IDX_W = $clog2(NREQ);

    state_t            r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_gidx;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic [DIV_W-1:0]  r_div_q;

    logic [DIV_W-1:0]  w_div_arr [NREQ];
    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W-1:0]  w_pick;
    int                w_idx;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic              w_rel_g;
    logic              w_req_g;
    logic              w_force;
    logic              w_exit;
    logic              w_run_en;
    logic              w_tick;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_div
        assign w_div_arr[gi] = div_in[gi*DIV_W +: DIV_W];
    end

    // round-robin search starting at r_ptr, wrapping past the top index
    always_comb begin
        w_found = 1'b0;
        w_win   = {IDX_W{1'b0}};
        w_pick  = {IDX_W{1'b0}};
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end else begin
                w_idx = w_idx;
            end
            w_pick = IDX_W'(w_idx);
            if (!w_found && req[w_pick]) begin
                w_found = 1'b1;
                w_win   = w_pick;
            end else begin
                w_found = w_found;
            end
        end
    end

    // pointer moves just past the releasing owner so it becomes lowest priority
    always_comb begin
        if (r_gidx == IDX_W'(NREQ - 1)) begin
            w_ptr_nxt = {IDX_W{1'b0}};
        end else begin
            w_ptr_nxt = r_gidx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_rel_g  = rel[r_gidx];
    assign w_req_g  = req[r_gidx];
    assign w_exit   = (r_state == RUN) && (w_rel_g || !w_req_g || w_force);
    assign w_run_en = (r_state == LOAD) || ((r_state == RUN) && !w_exit);

    // arbitration FSM with registered grant, busy and divider capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= {IDX_W{1'b0}};
            r_gidx  <= {IDX_W{1'b0}};
            r_gnt   <= {NREQ{1'b0}};
            r_busy  <= 1'b0;
            r_div_q <= {DIV_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= LOAD;
                        r_gidx  <= w_win;
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_busy  <= 1'b1;
                        r_div_q <= w_div_arr[w_win];
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= {NREQ{1'b0}};
                        r_busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_exit) begin
                        r_state <= IDLE;
                        r_gnt   <= {NREQ{1'b0}};
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_nxt;
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= {NREQ{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // counting starts in LOAD (count already zero) so the first tick lands on the first RUN cycle
    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!w_run_en),
        .en    (w_run_en),
        .div   (r_div_q),
        .tick  (w_tick)
    );

`ifdef TICK_ARBITER_TIMEOUT_EN
    logic [7:0] r_tcnt;
    logic       r_timeout;

    assign w_force = (r_state == RUN) && (max_ticks != 8'd0) && (r_tcnt >= max_ticks);

    // per-grant tick budget; the timeout pulse coincides with the forced return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (r_state == LOAD) begin
                r_tcnt <= 8'd0;
            end else if (w_tick) begin
                r_tcnt <= sat_inc8(r_tcnt);
            end else begin
                r_tcnt <= r_tcnt;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_max;

    assign w_unused_max = ^max_ticks;
    assign w_force      = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign gnt  = r_gnt;
    assign busy = r_busy;
    assign tick = w_tick;

endmodule

// File: doc/tick_arbiter.md
TICK_ARBITER -- requirements
Module: tick_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter DIV_W, default 8: divider and counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req  in  NREQ  per-requester level request for the shared tick generator.
REQ-006 rel  in  NREQ  per-requester release pulse; honoured only from the granted requester.
REQ-007 div_in  in  NREQ*DIV_W  packed divider values; requester i at bits [i*DIV_W +: DIV_W].
REQ-008 max_ticks  in  8  tick budget per grant; 0 = unlimited (used only with the timeout feature).
REQ-009 gnt  out  NREQ  one-hot grant, or all zero.
REQ-010 busy  out  1  high in LOAD or RUN.
REQ-011 tick  out  1  one-cycle tick pulse for the granted requester.
REQ-012 timeout  out  1  one-cycle pulse on forced release; tied 0 when the feature is absent.

Function
REQ-013 States: IDLE, LOAD, RUN; exactly one state is active.
REQ-014 IDLE with any req bit high: pick the winner round-robin, starting at index ptr and wrapping; next state is LOAD.
REQ-015 LOAD: gnt = one-hot of the winner; winner's div_in latched into div_q; counter cleared to 0; next state is RUN.
REQ-016 RUN counter: cnt increments by 1 each cycle, and goes to 0 on the cycle after cnt == div_q; arithmetic is DIV_W bits.
REQ-017 tick is high while in RUN and cnt == 1; tick period = div_q + 1 cycles.
REQ-018 Latency: req first sampled in IDLE at edge N gives gnt high from N+1 and the first tick at cycle N+2.
REQ-019 div_q == 0 gives no tick ever; the grant is still held.
REQ-020 div_in changes during RUN are ignored until the next LOAD.
REQ-021 RUN exits to IDLE on the next edge when rel[g] is high or req[g] is low (g = granted index); gnt and tick are low in IDLE.
REQ-022 rel bits from non-granted requesters are ignored; rel in IDLE is ignored.
REQ-023 On leaving RUN, ptr = (g + 1) mod NREQ.
REQ-024 At least one IDLE cycle separates consecutive grants, including when release and another request coincide.
REQ-025 Requester g holding req high through release re-competes in the next IDLE at the lowest priority.

Reset
REQ-026 While rst_n is low, these are forced immediately (asynchronous): state = IDLE, ptr = 0, cnt = 0, div_q = 0, gnt = 0, busy = 0, tick = 0, timeout = 0.
REQ-027 Reset mid-RUN drops the grant at once; no tick or timeout is produced for that grant.

Configuration
REQ-028 Macro TICK_ARBITER_TIMEOUT_EN defined: a tick counter is cleared in LOAD and increments on each tick.
REQ-029 With the macro, tick count reaching a nonzero max_ticks forces exit to IDLE on the next edge with timeout high for one cycle; ptr advances as on release.
REQ-030 Macro undefined: no tick counter is built, timeout is tied 0, max_ticks is unused.

Structure
REQ-031 Shared package tick_arbiter_pkg holds the state enum (IDLE, LOAD, RUN) and default constants NREQ_DEF = 4 and DIV_W_DEF = 8.
REQ-032 The counter and tick compare are a sub-module tick_gen (inputs clk, rst_n, clr, en, div; output tick); the arbiter holds the FSM, ptr and grant logic.

Verification
REQ-033 Scenario: reset, then req = 0001, div_in[0] = 3 → gnt = 0001 one cycle later; ticks at cycles 2, 6, 10 after req.
REQ-034 Scenario: req = 1111 held, each grantee pulses rel after 1 tick → gnt order 0001, 0010, 0100, 1000, 0001 with one IDLE cycle between grants.
REQ-035 Scenario: granted 0 with div 5, then rel[1] and div_in[0] = 2 driven mid-RUN → no effect; tick period stays 6.
REQ-036 Scenario: div_in = 0 → gnt asserted, tick stays 0 for 50 cycles; rel then returns to IDLE.
REQ-037 Scenario: rst_n low in RUN at an arbitrary cycle → gnt, tick and busy go 0 asynchronously; after release the first grant goes to requester 0.
REQ-038 Scenario: TICK_ARBITER_TIMEOUT_EN with max_ticks = 3, div = 1 → exactly 3 ticks, a timeout pulse, gnt drops, and the next requester is granted.
